hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding logic.
- Tracks every in-flight register write issued from ID: which rd is pending and how many cycles remain until its value is forwardable.
- Stalls ID when a source operand cannot yet be forwarded (load-use, multi-cycle ALU op) or when a WAW would reorder.
- Sits between decode and the ID/EX pipeline register; consumes the WB commit to retire entries.

Parameters:
- NUM_REGS, 32, architectural register count
- REG_SEL, $clog2(NUM_REGS), register index width
- LOAD_LAT, 1, cycles after issue before a load result is forwardable
- LONG_LAT, 4, cycles after issue before a multi-cycle (mul/div) result is forwardable
- CNT_W, $clog2(LONG_LAT+1), countdown width

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_SEL  source 1 index
- id_rs2  input  REG_SEL  source 2 index
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_SEL  destination index
- id_reg_write  input  1  instruction writes rd
- id_is_load  input  1  producer is a load
- id_is_long  input  1  producer is multi-cycle
- id_flush  input  1  kill the ID instruction this cycle
- wb_rd  input  REG_SEL  WB destination
- wb_reg_write  input  1  WB commits a write
- stall  output  1  hold PC/IF/ID; insert bubble into EX
- pending_mask  output  NUM_REGS  per-register pending bit, for debug

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high (clk, rst).
- State per register r:
  - pend[r] (1 bit).
  - cnt[r] (CNT_W bits): cycles until the value is forwardable.
  - x0 is never pending.
- Reset: all pend=0, all cnt=0, stall=0, pending_mask=0. Reset mid-stall drops the stall on the next cycle.
- Combinational hazard:
  - raw1 = id_use_rs1 & id_rs1!=0 & pend[rs1] & cnt[rs1]!=0.
  - raw2 = same for rs2.
  - waw = id_reg_write & id_rd!=0 & pend[rd] & cnt[rd]!=0.
  - stall = id_valid & !id_flush & (raw1|raw2|waw).
  - Zero cycles added beyond this; stall asserts in the same cycle as the offending ID.
- Issue fires when id_valid & !stall & !id_flush & id_reg_write & id_rd!=0. On issue, the next state is:
  - pend[rd]=1.
  - cnt[rd]=LONG_LAT if id_is_long, else LOAD_LAT if id_is_load, else 0.
  - id_is_long has priority over id_is_load.
- Countdown: each cycle, every cnt[r]!=0 decrements by 1 and saturates at 0. A freshly issued entry loads its value without decrementing that cycle.
- Retire: wb_reg_write & wb_rd!=0 clears pend[wb_rd] and cnt[wb_rd].
- Simultaneous issue and retire on the same register: issue wins, so pend=1 with the new count.
- cnt=0 with pend=1: the value is forwardable and causes no stall. The forwarding unit supplies the data.
- Flush: only suppresses the current issue and stall. Existing entries are untouched.
- pending_mask: registered copy of pend, updated every cycle.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- When defined:
  - Adds output port perf_stall_cycles (32 bits) and output perf_waw_stalls (16 bits).
  - perf_stall_cycles increments on every cycle with stall=1.
  - perf_waw_stalls increments on stall cycles where waw=1 and raw1=raw2=0.
  - Both counters saturate at all-ones.
  - Both are cleared by rst.
- When undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Load-use: issue load rd=5 (LOAD_LAT=1), next cycle ID reads rs1=5 -> stall=1 for exactly 1 cycle, then stall=0. pending_mask[5]=1 until WB commits rd=5.
- ALU back-to-back: issue add rd=7, next ID reads rs2=7 -> stall stays 0 (cnt=0, forwardable).
- Long op: issue div rd=9 (LONG_LAT=4), dependent reads rs1=9 next cycle -> stall=1 for 4 cycles. With the stats feature enabled, perf_stall_cycles=4.
- WAW: issue div rd=3, next ID is add rd=3 with no sources -> stall for 4 cycles. perf_waw_stalls=4 when the feature is enabled.
- x0 and flush:
  - load rd=0, then read rs1=0 -> no stall, pending_mask=0.
  - load-use with id_flush=1 -> stall=0 and no new entry.
- Reset/collision:
  - rst asserted while stall=1 for a div -> stall=0 and pending_mask=0 the next cycle.
  - WB retire rd=4 in the same cycle as issue rd=4 load -> pend[4]=1, cnt[4]=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Sits beside decode and tracks every register write that ID has issued but
//   WB has not yet committed. Each destination register has a pending bit and
//   a countdown that says how many cycles remain before its value can be
//   forwarded. ID is stalled when a source it reads, or the destination it
//   would overwrite, is pending with a nonzero countdown.
//
//   Optional feature (macro HAZARD_STALL_STATS_EN): adds saturating stall
//   statistics counters perf_stall_cycles and perf_waw_stalls.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            source indices, qualified by id_use_rs1/id_use_rs2
//   id_rd, id_reg_write      destination index and write enable
//   id_is_load, id_is_long   producer class (long has priority)
//   id_flush                 kill the ID instruction this cycle
//   wb_rd, wb_reg_write      WB commit, retires the matching entry
//   stall                    hold PC/IF/ID and bubble EX (combinational)
//   pending_mask             registered per-register pending bits
//   perf_stall_cycles        (stats only) cycles with stall=1
//   perf_waw_stalls          (stats only) stall cycles caused only by WAW
// -----------------------------------------------------------------------------

// One tracking entry per architectural register.
module hazard_sb_entry #(
   parameter int CNT_W    = 3,
   parameter int LOAD_LAT = 1,
   parameter int LONG_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic             is_load,
   input  logic             is_long,
   input  logic             retire,
   output logic             pend,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0;
         cnt  <= '0;
      end else if (issue) begin
         // issue beats a same-cycle retire; the fresh count is not decremented
         pend <= 1'b1;
         cnt  <= is_long ? CNT_W'(LONG_LAT) : (is_load ? CNT_W'(LOAD_LAT) : '0);
      end else if (retire) begin
         pend <= 1'b0;
         cnt  <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end
endmodule

module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_SEL  = $clog2(NUM_REGS),
   parameter int LOAD_LAT = 1,
   parameter int LONG_LAT = 4,
   parameter int CNT_W    = $clog2(LONG_LAT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_SEL-1:0]  id_rs1,
   input  logic [REG_SEL-1:0]  id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REG_SEL-1:0]  id_rd,
   input  logic                id_reg_write,
   input  logic                id_is_load,
   input  logic                id_is_long,
   input  logic                id_flush,
   input  logic [REG_SEL-1:0]  wb_rd,
   input  logic                wb_reg_write,
   output logic                stall,
`ifdef HAZARD_STALL_STATS_EN
   output logic [31:0]         perf_stall_cycles,
   output logic [15:0]         perf_waw_stalls,
`endif
   output logic [NUM_REGS-1:0] pending_mask
);
   logic [NUM_REGS-1:0]            pend;
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [NUM_REGS-1:0]            issue_vec;
   logic [NUM_REGS-1:0]            retire_vec;
   logic [NUM_REGS-1:0]            pend_nxt;
   logic                           raw1, raw2, waw;
   logic                           issue_go, retire_go;

   // A pending entry with cnt=0 is forwardable and never blocks.
   assign raw1 = id_use_rs1 & (id_rs1 != '0) & pend[id_rs1] & (cnt[id_rs1] != '0);
   assign raw2 = id_use_rs2 & (id_rs2 != '0) & pend[id_rs2] & (cnt[id_rs2] != '0);
   assign waw  = id_reg_write & (id_rd != '0) & pend[id_rd] & (cnt[id_rd] != '0);

   assign stall     = id_valid & ~id_flush & (raw1 | raw2 | waw);
   // x0 never issues, so its entry stays idle forever
   assign issue_go  = id_valid & ~stall & ~id_flush & id_reg_write & (id_rd != '0);
   assign retire_go = wb_reg_write & (wb_rd != '0);

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
      assign issue_vec[r]  = issue_go  & (id_rd == REG_SEL'(r));
      assign retire_vec[r] = retire_go & (wb_rd == REG_SEL'(r));
      assign pend_nxt[r]   = issue_vec[r] | (pend[r] & ~retire_vec[r]);

      hazard_sb_entry #(
         .CNT_W    (CNT_W),
         .LOAD_LAT (LOAD_LAT),
         .LONG_LAT (LONG_LAT)
      ) u_ent (
         .clk     (clk),
         .rst     (rst),
         .issue   (issue_vec[r]),
         .is_load (id_is_load),
         .is_long (id_is_long),
         .retire  (retire_vec[r]),
         .pend    (pend[r]),
         .cnt     (cnt[r])
      );
   end

   // Debug copy loaded from the same next-state as the entries, so it always
   // matches pend after each edge.
   always_ff @(posedge clk) begin
      if (rst) pending_mask <= '0;
      else     pending_mask <= pend_nxt;
   end

`ifdef HAZARD_STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_waw_stalls   <= '0;
      end else begin
         if (stall && perf_stall_cycles != '1)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (stall && waw && !raw1 && !raw2 && perf_waw_stalls != '1)
            perf_waw_stalls <= perf_waw_stalls + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Driver applies one ID/WB stimulus per cycle, predicts stall and the
//   post-edge pending mask from a time-stamp model (each pending register
//   remembers the cycle at which it becomes forwardable) and queues the
//   prediction. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
   localparam int NR = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write;
   logic        id_is_load, id_is_long, id_flush, wb_reg_write;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        stall;
   logic [31:0] pending_mask;
`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] perf_stall_cycles;
   logic [15:0] perf_waw_stalls;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_is_load   (id_is_load),
      .id_is_long   (id_is_long),
      .id_flush     (id_flush),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .stall        (stall),
`ifdef HAZARD_STALL_STATS_EN
      .perf_stall_cycles (perf_stall_cycles),
      .perf_waw_stalls   (perf_waw_stalls),
`endif
      .pending_mask (pending_mask)
   );

   typedef struct {
      logic v, u1, u2, rw, ld, lg, fl, wrw, r;
      logic [4:0] rs1, rs2, rd, wrd;
   } stim_t;

   typedef struct {
      logic        stall;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   drv_done = 0;

   // reference model: pending flag plus absolute forwardable cycle
   bit      m_pend[NR];
   longint  m_ready[NR];
   longint  cyc = 0;
   longint  m_stall_cnt = 0;
   longint  m_waw_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '{v:0, u1:0, u2:0, rw:0, ld:0, lg:0, fl:0, wrw:0, r:0,
            rs1:0, rs2:0, rd:0, wrd:0};
      return s;
   endfunction

   function automatic bit blocked(input logic [4:0] x);
      return (x != 0) && m_pend[x] && (cyc < m_ready[x]);
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   r1, r2, ww, st;
      id_valid = s.v; id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_reg_write = s.rw;
      id_is_load = s.ld; id_is_long = s.lg; id_flush = s.fl;
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
      wb_rd = s.wrd; wb_reg_write = s.wrw; rst = s.r;

      r1 = s.u1 && blocked(s.rs1);
      r2 = s.u2 && blocked(s.rs2);
      ww = s.rw && blocked(s.rd);
      st = s.v && !s.fl && (r1 || r2 || ww);

      if (s.r) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_stall_cnt = 0;
         m_waw_cnt   = 0;
      end else begin
         if (st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
         if (st && ww && !r1 && !r2 && m_waw_cnt < 64'hFFFF) m_waw_cnt++;
         if (s.wrw && s.wrd != 0) m_pend[s.wrd] = 0;
         if (s.v && !st && !s.fl && s.rw && s.rd != 0) begin
            m_pend[s.rd]  = 1;
            m_ready[s.rd] = cyc + 1 + (s.lg ? 4 : (s.ld ? 1 : 0));
         end
      end

      e.stall = st;
      e.mask  = '0;
      for (int i = 0; i < NR; i++) e.mask[i] = m_pend[i];
      exp_q.push_back(e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // monitor: stall is checked mid-cycle, the mask predicted for the
   // following edge is checked on the next falling edge
   initial begin : monitor
      exp_t prev;
      bit   have_prev;
      have_prev = 0;
      forever begin
         @(negedge clk);
         if (have_prev) chk("pending_mask", pending_mask, prev.mask);
         if (exp_q.size() > 0) begin
            prev = exp_q.pop_front();
            chk("stall", {31'd0, stall}, {31'd0, prev.stall});
            have_prev = 1;
         end else begin
            have_prev = 0;
         end
      end
   end

   initial begin : driver
      stim_t s;
      foreach (m_pend[i]) begin m_pend[i] = 0; m_ready[i] = 0; end

      // power-on reset, checked directly
      s = nop(); s.r = 1;
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
      id_is_load = 0; id_is_long = 0; id_flush = 0; wb_reg_write = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_rd = 0; rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_mask", pending_mask, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
`ifdef HAZARD_STALL_STATS_EN
      chk("reset_perf_stall", perf_stall_cycles, 32'd0);
      chk("reset_perf_waw", {16'd0, perf_waw_stalls}, 32'd0);
`endif
      step(s);

      // load-use: one stall cycle, then the same reader proceeds
      s = nop(); s.v = 1; s.rw = 1; s.rd = 5; s.ld = 1; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 5; repeat (2) step(s);
      step(nop());
      s = nop(); s.wrw = 1; s.wrd = 5; step(s);

      // ALU back-to-back is forwardable
      s = nop(); s.v = 1; s.rw = 1; s.rd = 7; step(s);
      s = nop(); s.v = 1; s.u2 = 1; s.rs2 = 7; step(s);

      // long op: four stall cycles on a dependent read
      s = nop(); s.v = 1; s.rw = 1; s.rd = 9; s.lg = 1; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 9; repeat (5) step(s);

      // WAW behind a long op
      s = nop(); s.v = 1; s.rw = 1; s.rd = 3; s.lg = 1; step(s);
      s = nop(); s.v = 1; s.rw = 1; s.rd = 3; repeat (5) step(s);

      // x0 is never pending
      s = nop(); s.v = 1; s.rw = 1; s.rd = 0; s.ld = 1; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 0; step(s);

      // flush suppresses stall and issue
      s = nop(); s.v = 1; s.rw = 1; s.rd = 6; s.ld = 1; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 6; s.rw = 1; s.rd = 8; s.ld = 1; s.fl = 1; step(s);
      s.fl = 0; step(s);

      // reset in the middle of a long-op stall
      s = nop(); s.v = 1; s.rw = 1; s.rd = 10; s.lg = 1; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 10; step(s);
      s.r = 1; step(s);
      s.r = 0; step(s);

      // issue and retire of the same register in one cycle: issue wins
      s = nop(); s.v = 1; s.rw = 1; s.rd = 4; step(s);
      s = nop(); s.v = 1; s.rw = 1; s.rd = 4; s.ld = 1; s.wrw = 1; s.wrd = 4; step(s);
      s = nop(); s.v = 1; s.u1 = 1; s.rs1 = 4; repeat (2) step(s);

      // randomized traffic on a small register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         s.v   = ($urandom_range(0, 7) != 0);
         s.u1  = $urandom_range(0, 1);
         s.u2  = $urandom_range(0, 1);
         s.rw  = $urandom_range(0, 1);
         s.ld  = ($urandom_range(0, 2) == 0);
         s.lg  = ($urandom_range(0, 3) == 0);
         s.fl  = ($urandom_range(0, 9) == 0);
         s.wrw = ($urandom_range(0, 2) == 0);
         s.r   = ($urandom_range(0, 99) == 0);
         s.rs1 = 5'($urandom_range(0, 7));
         s.rs2 = 5'($urandom_range(0, 7));
         s.rd  = 5'($urandom_range(0, 7));
         s.wrd = 5'($urandom_range(0, 7));
         step(s);
      end

      step(nop());
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef HAZARD_STALL_STATS_EN
      chk("perf_stall_cycles", perf_stall_cycles, 32'(m_stall_cnt));
      chk("perf_waw_stalls", {16'd0, perf_waw_stalls}, {16'd0, 16'(m_waw_cnt)});
`endif
      drv_done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      if (!drv_done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1);
      end
   end
endmodule
